queue_flex: RTL and testbench

QUEUE_FLEX -- requirements
Module: queue_flex

---
 rtl/queue_flex_if.sv | 30 +++
 rtl/queue_flex.sv | 80 ++++++++
 tb/tb_queue_flex.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/queue_flex_if.sv
// Queue handshake bundle: the producer/consumer side drives master, the queue sits on slave.
interface queue_flex_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             clr;
   logic             wr;
   logic [WIDTH-1:0] wr_data;
   logic             rd;
   logic [WIDTH-1:0] rd_data;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clr, wr, wr_data, rd,
      input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, wr, wr_data, rd,
      output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/queue_flex.sv
// Register-based first-word-fall-through queue with occupancy count,
// programmable almost flags and sticky overflow/underflow indicators.
module queue_flex #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 1
) (
   input logic         clk,
   input logic         rst,
   queue_flex_if.slave q
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;

   logic             empty_c;
   logic             full_c;
   logic             rd_ok_c;
   logic             wr_ok_c;
   logic [PW-1:0]    wr_ptr_nxt_c;
   logic [PW-1:0]    rd_ptr_nxt_c;

   // Occupancy flags and accept decisions; a read frees a slot for a write on a full queue.
   always_comb begin
      empty_c      = (count_q == CW'(0));
      full_c       = (count_q == CW'(DEPTH));
      rd_ok_c      = q.rd & ~empty_c;
      wr_ok_c      = q.wr & (~full_c | rd_ok_c);
      wr_ptr_nxt_c = (wr_ptr == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr + PW'(1);
      rd_ptr_nxt_c = (rd_ptr == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr + PW'(1);
   end

   // Pointers, count and sticky errors; clr flushes and wins over wr/rd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (q.clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok_c) wr_ptr <= wr_ptr_nxt_c;
         if (rd_ok_c) rd_ptr <= rd_ptr_nxt_c;
         if (wr_ok_c && !rd_ok_c)      count_q <= count_q + CW'(1);
         else if (rd_ok_c && !wr_ok_c) count_q <= count_q - CW'(1);
         if (q.wr && !wr_ok_c) overflow_q  <= 1'b1;
         if (q.rd && empty_c)  underflow_q <= 1'b1;
      end
   end

   // Storage array; contents survive reset and clr since only pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_ok_c && !q.clr) mem[wr_ptr] <= q.wr_data;
   end

   // Head-of-queue presentation and status outputs.
   always_comb begin
      q.rd_data      = empty_c ? '0 : mem[rd_ptr];
      q.full         = full_c;
      q.empty        = empty_c;
      q.almost_full  = (count_q >= CW'(AF_LEVEL));
      q.almost_empty = (count_q <= CW'(AE_LEVEL));
      q.count        = count_q;
      q.overflow     = overflow_q;
      q.underflow    = underflow_q;
   end
endmodule

// File: tb/tb_queue_flex.sv
// Scoreboard bench for queue_flex: a DEPTH=8 and a DEPTH=5 instance driven by directed vectors.
module tb_queue_flex;
   logic clk;
   logic rst;

   int vectors     = 0;
   int miscompares = 0;

   queue_flex_if #(.WIDTH(16), .DEPTH(8)) i8 ();
   queue_flex_if #(.WIDTH(16), .DEPTH(5)) i5 ();

   queue_flex #(.WIDTH(16), .DEPTH(8)) u8 (.clk(clk), .rst(rst), .q(i8.slave));
   queue_flex #(.WIDTH(16), .DEPTH(5)) u5 (.clk(clk), .rst(rst), .q(i5.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected contents of each queue, plus expected sticky flags.
   logic [15:0] sb8[$];
   logic [15:0] sb5[$];
   logic        mov8, mun8, mov5, mun5;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the DEPTH=8 queue (AF_LEVEL=6, AE_LEVEL=1), sampled mid-cycle.
   always @(negedge clk) begin
      logic rdok, wrok;
      if (!rst) begin
         sb8.delete(); mov8 = 1'b0; mun8 = 1'b0;
      end else begin
         chk("count8", 32'(i8.count), 32'(sb8.size()));
         chk("empty8", 32'(i8.empty), 32'(sb8.size() == 0));
         chk("full8", 32'(i8.full), 32'(sb8.size() == 8));
         chk("afull8", 32'(i8.almost_full), 32'(sb8.size() >= 6));
         chk("aempty8", 32'(i8.almost_empty), 32'(sb8.size() <= 1));
         chk("ovf8", 32'(i8.overflow), 32'(mov8));
         chk("unf8", 32'(i8.underflow), 32'(mun8));
         if (sb8.size() == 0) chk("rdzero8", 32'(i8.rd_data), 32'(0));
         if (i8.clr) begin
            sb8.delete(); mov8 = 1'b0; mun8 = 1'b0;
         end else begin
            rdok = i8.rd && (sb8.size() != 0);
            wrok = i8.wr && ((sb8.size() < 8) || rdok);
            if (i8.rd && !rdok) mun8 = 1'b1;
            if (i8.wr && !wrok) mov8 = 1'b1;
            if (rdok) begin
               chk("data8", 32'(i8.rd_data), 32'(sb8[0]));
               void'(sb8.pop_front());
            end
            if (wrok) sb8.push_back(i8.wr_data);
         end
      end
   end

   // Monitor for the DEPTH=5 queue (AF_LEVEL=3, AE_LEVEL=1).
   always @(negedge clk) begin
      logic rdok, wrok;
      if (!rst) begin
         sb5.delete(); mov5 = 1'b0; mun5 = 1'b0;
      end else begin
         chk("count5", 32'(i5.count), 32'(sb5.size()));
         chk("empty5", 32'(i5.empty), 32'(sb5.size() == 0));
         chk("full5", 32'(i5.full), 32'(sb5.size() == 5));
         chk("afull5", 32'(i5.almost_full), 32'(sb5.size() >= 3));
         chk("aempty5", 32'(i5.almost_empty), 32'(sb5.size() <= 1));
         chk("ovf5", 32'(i5.overflow), 32'(mov5));
         chk("unf5", 32'(i5.underflow), 32'(mun5));
         if (sb5.size() == 0) chk("rdzero5", 32'(i5.rd_data), 32'(0));
         if (i5.clr) begin
            sb5.delete(); mov5 = 1'b0; mun5 = 1'b0;
         end else begin
            rdok = i5.rd && (sb5.size() != 0);
            wrok = i5.wr && ((sb5.size() < 5) || rdok);
            if (i5.rd && !rdok) mun5 = 1'b1;
            if (i5.wr && !wrok) mov5 = 1'b1;
            if (rdok) begin
               chk("data5", 32'(i5.rd_data), 32'(sb5[0]));
               void'(sb5.pop_front());
            end
            if (wrok) sb5.push_back(i5.wr_data);
         end
      end
   end

   // One clock of stimulus on each queue; returns 1 time unit after the edge.
   task automatic s8(input logic w, input logic [15:0] d, input logic r, input logic c);
      i8.wr = w; i8.wr_data = d; i8.rd = r; i8.clr = c;
      @(posedge clk); #1;
      i8.wr = 1'b0; i8.rd = 1'b0; i8.clr = 1'b0;
   endtask

   task automatic s5(input logic w, input logic [15:0] d, input logic r, input logic c);
      i5.wr = w; i5.wr_data = d; i5.rd = r; i5.clr = c;
      @(posedge clk); #1;
      i5.wr = 1'b0; i5.rd = 1'b0; i5.clr = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      i8.wr = 1'b0; i8.wr_data = '0; i8.rd = 1'b0; i8.clr = 1'b0;
      i5.wr = 1'b0; i5.wr_data = '0; i5.rd = 1'b0; i5.clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(i8.count), 32'd0);
      chk("rst_empty", 32'(i8.empty), 32'd1);
      chk("rst_full", 32'(i8.full), 32'd0);
      chk("rst_aempty", 32'(i8.almost_empty), 32'd1);
      chk("rst_afull", 32'(i8.almost_full), 32'd0);
      chk("rst_rddata", 32'(i8.rd_data), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Fill 0x0001..0x0008.
      for (int i = 1; i <= 8; i++) begin
         s8(1'b1, 16'(i), 1'b0, 1'b0);
         if (i == 5) chk("af_at5", 32'(i8.almost_full), 32'd0);
         if (i == 6) chk("af_at6", 32'(i8.almost_full), 32'd1);
      end
      chk("fill_full", 32'(i8.full), 32'd1);
      chk("fill_count", 32'(i8.count), 32'd8);
      chk("fill_head", 32'(i8.rd_data), 32'h0001);

      // Write into a full queue is rejected.
      s8(1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("ovf_set", 32'(i8.overflow), 32'd1);
      chk("ovf_count", 32'(i8.count), 32'd8);

      // Simultaneous read and write on a full queue.
      s8(1'b1, 16'hBEEF, 1'b1, 1'b0);
      chk("fullrw_count", 32'(i8.count), 32'd8);
      chk("fullrw_head", 32'(i8.rd_data), 32'h0002);
      for (int i = 0; i < 7; i++) s8(1'b0, 16'h0, 1'b1, 1'b0);
      chk("beef_8th", 32'(i8.rd_data), 32'h0000BEEF);
      s8(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain_empty", 32'(i8.empty), 32'd1);
      chk("drain_rddata", 32'(i8.rd_data), 32'd0);

      // Flush clears sticky overflow.
      s8(1'b0, 16'h0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(i8.overflow), 32'd0);

      // Simultaneous read and write on an empty queue.
      s8(1'b1, 16'h1234, 1'b1, 1'b0);
      chk("emptyrw_unf", 32'(i8.underflow), 32'd1);
      chk("emptyrw_count", 32'(i8.count), 32'd1);
      chk("emptyrw_data", 32'(i8.rd_data), 32'h1234);
      s8(1'b0, 16'h0, 1'b1, 1'b0);
      chk("emptyrw_drain", 32'(i8.empty), 32'd1);

      // DEPTH=5: 12 writes with interleaved reads, pointers wrap twice.
      for (int i = 0; i < 12; i++) s5(1'b1, 16'h0100 + 16'(i), (i >= 2), 1'b0);
      chk("wrap_count", 32'(i5.count), 32'd2);
      chk("wrap_head", 32'(i5.rd_data), 32'h010A);
      s5(1'b0, 16'h0, 1'b1, 1'b0);
      s5(1'b0, 16'h0, 1'b1, 1'b0);
      chk("wrap_empty", 32'(i5.empty), 32'd1);

      // Fill past full, then flush while a write is requested.
      for (int i = 0; i < 6; i++) s5(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      chk("d5_full", 32'(i5.full), 32'd1);
      chk("d5_ovf", 32'(i5.overflow), 32'd1);
      s5(1'b1, 16'h02FF, 1'b1, 1'b1);
      chk("clr_count", 32'(i5.count), 32'd0);
      chk("clr_empty", 32'(i5.empty), 32'd1);
      chk("clr_ovf5", 32'(i5.overflow), 32'd0);
      chk("clr_unf5", 32'(i5.underflow), 32'd0);

      // Asynchronous reset between clock edges.
      s5(1'b1, 16'h0300, 1'b0, 1'b0);
      s5(1'b1, 16'h0301, 1'b0, 1'b0);
      chk("prerst_count", 32'(i5.count), 32'd2);
      #2 rst = 1'b0;
      #1;
      chk("arst_count", 32'(i5.count), 32'd0);
      chk("arst_empty", 32'(i5.empty), 32'd1);
      chk("arst_rddata", 32'(i5.rd_data), 32'd0);
      chk("arst_aempty", 32'(i5.almost_empty), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      s5(1'b1, 16'hA5A5, 1'b0, 1'b0);
      chk("postrst_data", 32'(i5.rd_data), 32'hA5A5);
      chk("postrst_count", 32'(i5.count), 32'd1);
      s5(1'b0, 16'h0, 1'b1, 1'b0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
